// File: rtl/map_pkg.sv
// Shared constants and FSM state type for the per-frame collision probe scheduler.
// COLLISION_MIDPOINT_EN adds a third, mid-edge probe to every edge.
package map_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [1:0] EDGE_UP    = 2'd0;
  localparam logic [1:0] EDGE_DOWN  = 2'd1;
  localparam logic [1:0] EDGE_LEFT  = 2'd2;
  localparam logic [1:0] EDGE_RIGHT = 2'd3;

`ifdef COLLISION_MIDPOINT_EN
  localparam int PROBES_PER_EDGE = 3;
`else
  localparam int PROBES_PER_EDGE = 2;
`endif
  localparam int PROBES_PER_PLAYER = 4 * PROBES_PER_EDGE;
  localparam int NUM_PROBES        = 2 * PROBES_PER_PLAYER;
  localparam int IDX_W             = 5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;
endpackage

// File: rtl/collision_probe_gen.sv
// Combinational probe coordinate generator: maps a probe index and a top-left
// position to an 11-bit signed pixel coordinate, its edge and an out-of-range flag.
module collision_probe_gen
  import map_pkg::*;
#(
  parameter int CHAR_W = 32,
  parameter int CHAR_H = 32
) (
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic signed [10:0] px_o,
  output logic signed [10:0] py_o,
  output logic [1:0]        edge_o,
  output logic              oor_o
);
  localparam logic signed [10:0] ONE        = 11'sd1;
  localparam logic signed [10:0] OFF_W      = 11'(CHAR_W);
  localparam logic signed [10:0] OFF_W_LAST = 11'(CHAR_W - 1);
  localparam logic signed [10:0] OFF_W_MID  = 11'(CHAR_W / 2);
  localparam logic signed [10:0] OFF_H      = 11'(CHAR_H);
  localparam logic signed [10:0] OFF_H_LAST = 11'(CHAR_H - 1);
  localparam logic signed [10:0] OFF_H_MID  = 11'(CHAR_H / 2);

  logic [IDX_W-1:0]  rem;
  logic [IDX_W-1:0]  corner;
  logic signed [10:0] xs;
  logic signed [10:0] ys;
  logic signed [10:0] along_x;
  logic signed [10:0] along_y;

  always_comb begin
    rem    = idx_i % IDX_W'(PROBES_PER_PLAYER);
    edge_o = 2'(rem / IDX_W'(PROBES_PER_EDGE));
    corner = rem % IDX_W'(PROBES_PER_EDGE);
    xs     = signed'({1'b0, x_i});
    ys     = signed'({1'b0, y_i});

    // Position along the edge: first corner, second corner, then midpoint.
    if (corner == '0) begin
      along_x = xs;
      along_y = ys;
    end else if (corner == IDX_W'(1)) begin
      along_x = xs + OFF_W_LAST;
      along_y = ys + OFF_H_LAST;
    end else begin
      along_x = xs + OFF_W_MID;
      along_y = ys + OFF_H_MID;
    end

    px_o = along_x;
    py_o = along_y;
    case (edge_o)
      EDGE_UP:   py_o = ys - ONE;
      EDGE_DOWN: py_o = ys + OFF_H;
      EDGE_LEFT: px_o = xs - ONE;
      default:   px_o = xs + OFF_W;
    endcase

    oor_o = px_o[10] | py_o[10] |
            (px_o[9:0] >= 10'(SCREEN_W)) | (py_o[9:0] >= 10'(SCREEN_H));
  end
endmodule

// File: rtl/map_collision_sched.sv
// Per-frame collision probe scheduler: walks a fixed probe sequence through one
// shared wall-map port and publishes per-edge blocked flags (COLLISION_MIDPOINT_EN adds midpoints).
module map_collision_sched
  import map_pkg::*;
#(
  parameter int CHAR_W = 32,
  parameter int CHAR_H = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic [9:0] p0_x,
  input  logic [9:0] p0_y,
  input  logic [9:0] p1_x,
  input  logic [9:0] p1_y,
  output logic [9:0] query_x,
  output logic [9:0] query_y,
  input  logic       query_is_wall,
  output logic [3:0] p0_blk,
  output logic [3:0] p1_blk,
  output logic       busy,
  output logic       done,
  output logic       overrun
);
  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [9:0]       x0_q, y0_q, x1_q, y1_q;
  logic [3:0]       acc0_q, acc1_q, acc0_d, acc1_d;
  logic [9:0]       qx_q, qy_q;
  logic             cur_oor_q;
  logic [1:0]       cur_edge_q;
  logic             cur_player_q;
  logic [3:0]       blk0_q, blk1_q;
  logic             busy_q, done_q, ovr_q;

  logic             start;
  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_player;
  logic [9:0]       src_x, src_y;
  logic             last;
  logic             hit;
  logic [3:0]       edge_mask;
  logic signed [10:0] gen_px, gen_py;
  logic [1:0]       gen_edge;
  logic             gen_oor;

  // The generator always looks one probe ahead so query_x/query_y are registered.
  always_comb begin
    start      = frame_start && (state_q != S_RUN);
    nxt_idx    = (state_q == S_RUN) ? idx_q + IDX_W'(1) : '0;
    nxt_player = (nxt_idx >= IDX_W'(PROBES_PER_PLAYER));
    if (start) begin
      src_x = p0_x;
      src_y = p0_y;
    end else if (nxt_player) begin
      src_x = x1_q;
      src_y = y1_q;
    end else begin
      src_x = x0_q;
      src_y = y0_q;
    end
    last      = (idx_q == IDX_W'(NUM_PROBES - 1));
    hit       = cur_oor_q | query_is_wall;
    edge_mask = hit ? (4'b0001 << cur_edge_q) : 4'b0000;
    acc0_d    = acc0_q | (cur_player_q ? 4'b0000 : edge_mask);
    acc1_d    = acc1_q | (cur_player_q ? edge_mask : 4'b0000);
  end

  collision_probe_gen #(
    .CHAR_W (CHAR_W),
    .CHAR_H (CHAR_H)
  ) u_gen (
    .x_i    (src_x),
    .y_i    (src_y),
    .idx_i  (nxt_idx),
    .px_o   (gen_px),
    .py_o   (gen_py),
    .edge_o (gen_edge),
    .oor_o  (gen_oor)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      acc0_q       <= '0;
      acc1_q       <= '0;
      qx_q         <= '0;
      qy_q         <= '0;
      cur_oor_q    <= 1'b0;
      cur_edge_q   <= '0;
      cur_player_q <= 1'b0;
      blk0_q       <= '0;
      blk1_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (frame_start) ovr_q <= 1'b1;
          acc0_q <= acc0_d;
          acc1_q <= acc1_d;
          if (last) begin
            blk0_q  <= acc0_d;
            blk1_q  <= acc1_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_PUBLISH;
          end else begin
            idx_q        <= nxt_idx;
            qx_q         <= 10'(gen_px);
            qy_q         <= 10'(gen_py);
            cur_oor_q    <= gen_oor;
            cur_edge_q   <= gen_edge;
            cur_player_q <= nxt_player;
          end
        end
        default: begin
          if (start) begin
            x0_q         <= p0_x;
            y0_q         <= p0_y;
            x1_q         <= p1_x;
            y1_q         <= p1_y;
            idx_q        <= '0;
            acc0_q       <= '0;
            acc1_q       <= '0;
            qx_q         <= 10'(gen_px);
            qy_q         <= 10'(gen_py);
            cur_oor_q    <= gen_oor;
            cur_edge_q   <= gen_edge;
            cur_player_q <= nxt_player;
            busy_q       <= 1'b1;
            state_q      <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign query_x = qx_q;
  assign query_y = qy_q;
  assign p0_blk  = blk0_q;
  assign p1_blk  = blk1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_map_collision_sched.sv
// Bench for map_collision_sched: directed wall-map scenarios plus random frames,
// checked against a probe-list reference model (COLLISION_MIDPOINT_EN selects 3 probes/edge).
module tb_map_collision_sched;
`ifdef COLLISION_MIDPOINT_EN
  localparam int PPE = 3;
`else
  localparam int PPE = 2;
`endif
  localparam int NP = 8 * PPE;
  localparam int CW = 32;
  localparam int CH = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic [9:0] p0_x, p0_y, p1_x, p1_y;
  logic [9:0] query_x, query_y;
  logic       query_is_wall;
  logic [3:0] p0_blk, p1_blk;
  logic       busy, done, overrun;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [19:0] exp_q[$];
  logic [3:0]  exp_blk0, exp_blk1, pub_blk0, pub_blk1;
  logic [19:0] last_query;
  logic        exp_ovr;
  logic        inject;

  // ---------------- clock / DUT ----------------
  always #5 clk = ~clk;

  map_collision_sched #(.CHAR_W(CW), .CHAR_H(CH)) dut (
    .Clk           (clk),
    .Reset         (rst),
    .frame_start   (frame_start),
    .p0_x          (p0_x),
    .p0_y          (p0_y),
    .p1_x          (p1_x),
    .p1_y          (p1_y),
    .query_x       (query_x),
    .query_y       (query_y),
    .query_is_wall (query_is_wall),
    .p0_blk        (p0_blk),
    .p1_blk        (p1_blk),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun)
  );

  // Production wall map, optionally with one extra wall pixel.
  function automatic logic wall_at(input logic inj, input int x, input int y);
    if (inj && x == 316 && y == 199) return 1'b1;
    return (y >= 455) || (x < 25) || (x < 215 && y >= 391 && y <= 410);
  endfunction

  assign query_is_wall = wall_at(inject, int'(query_x), int'(query_y));

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: list every probe point in order and OR results per edge.
  task automatic build_model(input int x0, input int y0, input int x1, input int y1);
    int px, py, bx, by;
    logic hit;
    exp_q.delete();
    exp_blk0 = 4'b0000;
    exp_blk1 = 4'b0000;
    for (int p = 0; p < 2; p++) begin
      bx = (p == 0) ? x0 : x1;
      by = (p == 0) ? y0 : y1;
      for (int e = 0; e < 4; e++) begin
        for (int k = 0; k < PPE; k++) begin
          if (e < 2) begin
            px = (k == 0) ? bx : (k == 1) ? bx + CW - 1 : bx + CW / 2;
            py = (e == 0) ? by - 1 : by + CH;
          end else begin
            py = (k == 0) ? by : (k == 1) ? by + CH - 1 : by + CH / 2;
            px = (e == 2) ? bx - 1 : bx + CW;
          end
          hit = (px < 0) || (px >= 640) || (py < 0) || (py >= 480) || wall_at(inject, px, py);
          exp_q.push_back({10'(px & 1023), 10'(py & 1023)});
          if (hit) begin
            if (p == 0) exp_blk0[e] = 1'b1;
            else        exp_blk1[e] = 1'b1;
          end
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the negedge of the publish cycle (cycle NP+1).
  task automatic run_frame(input int x0, input int y0, input int x1, input int y1,
                           input int fs2_cyc, input int rst_cyc);
    logic aborted;
    logic [19:0] q;
    aborted = 1'b0;
    build_model(x0, y0, x1, y1);
    p0_x = 10'(x0); p0_y = 10'(y0); p1_x = 10'(x1); p1_y = 10'(y1);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int c = 1; c <= NP + 1; c++) begin
      if (c == fs2_cyc) begin
        frame_start = 1'b1;
        p0_x = 10'($urandom_range(0, 639)); p0_y = 10'($urandom_range(0, 479));
        p1_x = 10'($urandom_range(0, 639)); p1_y = 10'($urandom_range(0, 479));
      end
      if (c == rst_cyc) rst = 1'b1;
      @(negedge clk);
      if (aborted) begin
        check_eq("abort_busy", 32'(busy), 32'(0));
        check_eq("abort_done", 32'(done), 32'(0));
        check_eq("abort_ovr", 32'(overrun), 32'(0));
        check_eq("abort_query", 32'({query_x, query_y}), 32'(0));
        check_eq("abort_blk", 32'({p0_blk, p1_blk}), 32'(0));
      end else begin
        check_eq("busy", 32'(busy), 32'(c <= NP));
        check_eq("done", 32'(done), 32'(c == NP + 1));
        check_eq("overrun", 32'(overrun), 32'(exp_ovr));
        if (c <= NP) begin
          q = exp_q.pop_front();
          last_query = q;
          check_eq("query", 32'({query_x, query_y}), 32'(q));
          check_eq("blk_hold", 32'({p0_blk, p1_blk}), 32'({pub_blk0, pub_blk1}));
        end else begin
          pub_blk0 = exp_blk0;
          pub_blk1 = exp_blk1;
          check_eq("blk", 32'({p0_blk, p1_blk}), 32'({exp_blk0, exp_blk1}));
          check_eq("query_hold", 32'({query_x, query_y}), 32'(last_query));
        end
      end
      if (c == NP + 1) break;
      @(posedge clk); #1;
      frame_start = 1'b0;
      if (c == fs2_cyc) exp_ovr = 1'b1;
      if (c == rst_cyc) begin
        rst = 1'b0;
        aborted = 1'b1;
        exp_ovr = 1'b0;
        pub_blk0 = 4'b0000;
        pub_blk1 = 4'b0000;
        last_query = '0;
      end
    end
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      p0_x = 10'($urandom_range(0, 639));
      p1_y = 10'($urandom_range(0, 479));
      @(negedge clk);
      check_eq("idle_busy", 32'(busy), 32'(0));
      check_eq("idle_done", 32'(done), 32'(0));
      check_eq("idle_ovr", 32'(overrun), 32'(exp_ovr));
      check_eq("idle_blk", 32'({p0_blk, p1_blk}), 32'({pub_blk0, pub_blk1}));
      check_eq("idle_query", 32'({query_x, query_y}), 32'(last_query));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mode, rx0, ry0, rx1, ry1;
    rst = 1'b1; frame_start = 1'b0; inject = 1'b0;
    p0_x = '0; p0_y = '0; p1_x = '0; p1_y = '0;
    exp_ovr = 1'b0; pub_blk0 = '0; pub_blk1 = '0; last_query = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_done", 32'(done), 32'(0));
    check_eq("rst_ovr", 32'(overrun), 32'(0));
    check_eq("rst_blk", 32'({p0_blk, p1_blk}), 32'(0));
    check_eq("rst_query", 32'({query_x, query_y}), 32'(0));
    idle(2);

    run_frame(300, 200, 400, 200, 0, 0);
    check_eq("free_space", 32'({p0_blk, p1_blk}), 32'(8'b0000_0000));
    idle(1);

    run_frame(300, 423, 100, 411, 0, 0);
    check_eq("floor_platform", 32'({p0_blk, p1_blk}), 32'(8'b0010_0001));
    // Next frame_start lands in the publish cycle.
    run_frame(25, 200, 0, 200, 0, 0);
    check_eq("left_wall", 32'({p0_blk, p1_blk}), 32'(8'b0100_0111));
    idle(1);

    run_frame(300, 200, 400, 200, 5, 0);
    check_eq("overrun_blk", 32'({p0_blk, p1_blk}), 32'(8'b0000_0000));
    idle(3);

    run_frame(300, 423, 100, 411, 0, 8);
    idle(2);
    run_frame(300, 423, 100, 411, 0, 0);
    check_eq("after_reset", 32'({p0_blk, p1_blk}), 32'(8'b0010_0001));
    idle(1);

    inject = 1'b1;
    run_frame(300, 200, 400, 200, 0, 0);
`ifdef COLLISION_MIDPOINT_EN
    check_eq("midpoint_inject", 32'(p0_blk), 32'(4'b0001));
`else
    check_eq("corner_inject", 32'(p0_blk), 32'(4'b0000));
`endif
    inject = 1'b0;
    idle(1);

    repeat (24) begin
      rx0 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 639));
      ry0 = ($urandom_range(0, 3) == 0) ? 479 : int'($urandom_range(0, 479));
      rx1 = ($urandom_range(0, 3) == 0) ? 639 : int'($urandom_range(0, 639));
      ry1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 479));
      mode = int'($urandom_range(0, 9));
      if (mode == 0)      run_frame(rx0, ry0, rx1, ry1, int'($urandom_range(1, NP)), 0);
      else if (mode == 1) run_frame(rx0, ry0, rx1, ry1, 0, int'($urandom_range(1, NP)));
      else                run_frame(rx0, ry0, rx1, ry1, 0, 0);
      idle(int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/map_collision_sched.md
# map_collision_sched

Per-frame collision probe scheduler for the two player characters. On each frame pulse it latches both player positions, issues a fixed sequence of pixel queries through one shared map lookup port (the wall map's X/Y → is_Wall path), and publishes per-edge blocked flags. Motion logic reads these flags before applying velocity. It sits between the frame-timing logic, the player motion blocks and the combinational wall map.

## Interface
Parameters:
- CHAR_W, 32: character sprite width in pixels.
- CHAR_H, 32: character sprite height in pixels.

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse, once per frame.
- p0_x, p0_y  in  10 each  player 0 top-left pixel.
- p1_x, p1_y  in  10 each  player 1 top-left pixel.
- query_x, query_y  out  10 each  registered probe coordinate to the map.
- query_is_wall  in  1  map result for the current query, combinational, same cycle.
- p0_blk, p1_blk  out  4 each  blocked flags: [0] up, [1] down, [2] left, [3] right.
- busy  out  1  probe sequence in progress.
- done  out  1  one-cycle pulse when new flags are published.
- overrun  out  1  sticky; set when frame_start arrives while busy.

## Operation
- FSM states: IDLE, RUN, PUBLISH.
  - IDLE: on frame_start, latch all four positions, clear the probe index and accumulators, and go to RUN.
  - RUN: each cycle drive one probe and sample its result at the end of that cycle. After the last probe, go to PUBLISH.
  - PUBLISH: copy the accumulators to p0_blk/p1_blk, pulse done, and return to IDLE. frame_start is accepted in PUBLISH exactly as in IDLE.
- Probe order:
  - Player 0 first, then player 1.
  - Within each player, edges in the order up, down, left, right.
  - Two probes per edge, at the first corner then the second.
- Probe coordinates (x, y = latched top-left):
  - up: (x, y-1) and (x+CHAR_W-1, y-1).
  - down: (x, y+CHAR_H) and (x+CHAR_W-1, y+CHAR_H).
  - left: (x-1, y) and (x-1, y+CHAR_H-1).
  - right: (x+CHAR_W, y) and (x+CHAR_W, y+CHAR_H-1).
- Arithmetic rules:
  - Compute probe coordinates in 11-bit signed.
  - A coordinate that is negative, X ≥ 640 or Y ≥ 480 is out of range. Its probe result is forced to 1 and query_is_wall is ignored for that probe.
  - For an out-of-range probe, query_x/query_y are driven with the low 10 bits of the coordinate.
- Edge flag = OR of that edge's probe results.
- While busy, frame_start is ignored and sets overrun. Neither the sequence nor the latched positions change.
- Between PUBLISH events, p0_blk/p1_blk hold their last published values.
- Reset at any time, including mid-RUN, has the following effect on the next cycle:
  - State returns to IDLE.
  - p0_blk, p1_blk, busy, done, overrun, query_x and query_y all become 0.
  - No done pulse is issued for the aborted run.

## Timing
- Cycle numbering: frame_start is high in cycle 0.
- Probe i is driven on query_x/query_y in cycle 1+i, for i = 0..15.
- Cycle 17 is PUBLISH: done=1 and the new flags are visible in that cycle.
- busy is high in cycles 1..16 and low in 17.
- A frame_start in cycle 17 starts a new run with probe 0 in cycle 18.
- Latency from frame_start to done is 17 cycles (25 with the midpoint probes enabled).
- query_x/query_y hold their last value while in IDLE.

## Configuration
- COLLISION_MIDPOINT_EN defined: adds a third probe per edge at the edge midpoint.
  - Horizontal edges use X at x+CHAR_W/2; vertical edges use Y at y+CHAR_H/2.
  - The midpoint probe is ordered after the two corners.
  - 24 probes per run; PUBLISH in cycle 25.
- Undefined: 16 probes as described under Operation.

## Structure
- Shared package map_pkg holds:
  - SCREEN_W=640 and SCREEN_H=480.
  - The edge index constants (EDGE_UP=0, EDGE_DOWN=1, EDGE_LEFT=2, EDGE_RIGHT=3).
  - PROBES_PER_EDGE (2, or 3 under the macro).
  - The FSM state enum.
- Sub-module collision_probe_gen is combinational. It takes the latched x, y and the probe index, and returns the 11-bit signed coordinate pair plus an out_of_range flag.

## Test plan
Use the production wall map (floor Y≥455, left wall X<25, platform X<215 for Y 391..410), CHAR_W=CHAR_H=32.
- Free space: p0=(300,200), p1=(400,200), frame_start in cycle 0 -> p0_blk=p1_blk=4'b0000, done in cycle 17, busy high only in cycles 1..16.
- Floor contact: p0=(300,423), so down Y=455 -> p0_blk=4'b0010. Platform underside: p1=(100,411), so up Y=410 -> p1_blk=4'b0001.
- Left wall and underflow:
  - p0=(25,200) -> p0_blk=4'b0100.
  - p1=(0,200): left is out of range and up/down X=0 are inside the wall -> p1_blk=4'b0111.
- Overrun: second frame_start in cycle 5 -> overrun=1 from cycle 6; flags and done in cycle 17 are unchanged from the first run; no second run.
- Reset mid-run: Reset high in cycle 8 -> all outputs 0 in cycle 9; no done. A fresh frame_start afterwards completes normally in 17 cycles.
- With COLLISION_MIDPOINT_EN defined: probe index reaches 23 and done is in cycle 25. p0=(300,200) with a wall region injected only at (316,199) -> p0_blk=4'b0001.
